hazard_stall_unit: RTL and testbench

- Producer-side counterpart to the pipeline forwarding logic: detects every hazard that forwarding cannot resolve.
- Drives the matching stall, bubble and flush controls.
- Sits beside the ID stage and owns a multi-cycle MUL/DIV busy tracker, so HI/LO consumers wait for the iterative unit.
- Also keeps a saturating stall-cycle performance counter.

---
 rtl/hazard_stall_unit_if.sv | 43 ++++
 rtl/hazard_stall_unit.sv | 126 ++++++++++++
 tb/tb_hazard_stall_unit.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/hazard_stall_unit_if.sv
// Bundle of the ID/EX/MEM hazard inputs and the stall/flush/MUL-DIV status
// outputs exchanged between the pipeline and hazard_stall_unit.
interface hazard_stall_unit_if #(
  parameter int CNT_WIDTH = 32
);
  logic [4:0]           ID_rs;
  logic [4:0]           ID_rt;
  logic                 ID_usesRt;
  logic                 ID_isBranch;
  logic                 ID_BranchTaken;
  logic                 ID_readsHiLo;
  logic                 ID_isMulDiv;
  logic [4:0]           EX_WriteReg;
  logic                 EX_RegWrite;
  logic                 EX_MemRead;
  logic                 EX_MulDivStart;
  logic [4:0]           MEM_WriteReg;
  logic                 MEM_MemRead;
  logic                 PCWrite;
  logic                 IFID_Write;
  logic                 IDEX_Bubble;
  logic                 IFID_Flush;
  logic                 MD_Busy;
  logic                 MD_Done;
  logic                 MD_Overlap;
  logic [CNT_WIDTH-1:0] StallCount;

  modport master (
    output ID_rs, ID_rt, ID_usesRt, ID_isBranch, ID_BranchTaken, ID_readsHiLo,
           ID_isMulDiv, EX_WriteReg, EX_RegWrite, EX_MemRead, EX_MulDivStart,
           MEM_WriteReg, MEM_MemRead,
    input  PCWrite, IFID_Write, IDEX_Bubble, IFID_Flush, MD_Busy, MD_Done,
           MD_Overlap, StallCount
  );

  modport slave (
    input  ID_rs, ID_rt, ID_usesRt, ID_isBranch, ID_BranchTaken, ID_readsHiLo,
           ID_isMulDiv, EX_WriteReg, EX_RegWrite, EX_MemRead, EX_MulDivStart,
           MEM_WriteReg, MEM_MemRead,
    output PCWrite, IFID_Write, IDEX_Bubble, IFID_Flush, MD_Busy, MD_Done,
           MD_Overlap, StallCount
  );
endinterface

// File: rtl/hazard_stall_unit.sv
// ID-stage hazard detector: stalls on hazards forwarding cannot cover, tracks the
// iterative MUL/DIV unit so HI/LO readers wait, and counts stalled cycles.
module hazard_stall_unit #(
  parameter int MD_LATENCY = 4,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                Clk,
  input  logic                Reset,
  hazard_stall_unit_if.slave  bus
);

  typedef enum logic [0:0] {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  localparam logic [3:0] MD_LOAD = 4'(MD_LATENCY - 1);

  function automatic logic src_match(input logic [4:0] r, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic uses_rt);
    return (r != 5'd0) && ((r == rs) || (uses_rt && (r == rt)));
  endfunction

  md_state_e            state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 done_q, done_d;
  logic                 overlap_q, overlap_d;
  logic [CNT_WIDTH-1:0] stall_count_q, stall_count_d;
  logic                 ex_match_s, mem_match_s;
  logic                 load_use_s, branch_ex_s, branch_load_s, hilo_s, stall_s;

  // Hazard detection against the EX and MEM producers
  always_comb begin
    ex_match_s    = src_match(bus.EX_WriteReg, bus.ID_rs, bus.ID_rt, bus.ID_usesRt);
    mem_match_s   = src_match(bus.MEM_WriteReg, bus.ID_rs, bus.ID_rt, bus.ID_usesRt);
    load_use_s    = bus.EX_MemRead && ex_match_s;
    branch_ex_s   = bus.ID_isBranch && bus.EX_RegWrite && ex_match_s;
    branch_load_s = bus.ID_isBranch && bus.MEM_MemRead && mem_match_s;
    hilo_s        = (bus.ID_readsHiLo || bus.ID_isMulDiv) &&
                    ((state_q == MD_BUSY) || bus.EX_MulDivStart);
    stall_s       = load_use_s || branch_ex_s || branch_load_s || hilo_s;
  end

  // Pipeline controls; reset holds the pipe free-running with no squash
  always_comb begin
    if (Reset) begin
      bus.PCWrite     = 1'b1;
      bus.IFID_Write  = 1'b1;
      bus.IDEX_Bubble = 1'b0;
      bus.IFID_Flush  = 1'b0;
    end else begin
      bus.PCWrite     = !stall_s;
      bus.IFID_Write  = !stall_s;
      bus.IDEX_Bubble = stall_s;
      // A stalled branch compared stale operands, so its taken decision is void
      bus.IFID_Flush  = bus.ID_BranchTaken && !stall_s;
    end
  end

  // MUL/DIV busy tracker next state; a start while busy is flagged, never restarts
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    overlap_d = overlap_q;
    case (state_q)
      MD_IDLE: begin
        if (bus.EX_MulDivStart) begin
          state_d = MD_BUSY;
          cnt_d   = MD_LOAD;
        end else begin
          state_d = MD_IDLE;
        end
      end
      MD_BUSY: begin
        if (bus.EX_MulDivStart) begin
          overlap_d = 1'b1;
        end else begin
          overlap_d = overlap_q;
        end
        if (cnt_q == 4'd0) begin
          state_d = MD_IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = MD_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Saturating stall-cycle counter
  always_comb begin
    if (stall_s && (stall_count_q != {CNT_WIDTH{1'b1}})) begin
      stall_count_d = stall_count_q + CNT_WIDTH'(1);
    end else begin
      stall_count_d = stall_count_q;
    end
  end

  // State registers; reset aborts an in-flight MUL/DIV without a done pulse
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q       <= MD_IDLE;
      cnt_q         <= 4'd0;
      done_q        <= 1'b0;
      overlap_q     <= 1'b0;
      stall_count_q <= {CNT_WIDTH{1'b0}};
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      done_q        <= done_d;
      overlap_q     <= overlap_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign bus.MD_Busy    = (state_q == MD_BUSY);
  assign bus.MD_Done    = done_q;
  assign bus.MD_Overlap = overlap_q;
  assign bus.StallCount = stall_count_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed and randomized check of hazard_stall_unit against a cycle model built
// from remaining-busy-cycles bookkeeping and the hazard rules.
module tb_hazard_stall_unit;

  localparam int LAT = 4;
  localparam int CW  = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  // model state
  int   m_rem = 0;
  bit   m_done = 1'b0;
  bit   m_ovl = 1'b0;
  int   m_cnt = 0;

  hazard_stall_unit_if #(.CNT_WIDTH(CW)) bus ();

  hazard_stall_unit #(.MD_LATENCY(LAT), .CNT_WIDTH(CW)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit reads(input logic [4:0] r);
    return (r != 5'd0) && ((r == bus.ID_rs) || (bus.ID_usesRt && (r == bus.ID_rt)));
  endfunction

  function automatic bit model_stall();
    bit s;
    s = 1'b0;
    if (bus.EX_MemRead && reads(bus.EX_WriteReg)) s = 1'b1;
    if (bus.ID_isBranch && bus.EX_RegWrite && reads(bus.EX_WriteReg)) s = 1'b1;
    if (bus.ID_isBranch && bus.MEM_MemRead && reads(bus.MEM_WriteReg)) s = 1'b1;
    if ((bus.ID_readsHiLo || bus.ID_isMulDiv) && ((m_rem > 0) || bus.EX_MulDivStart)) s = 1'b1;
    return s;
  endfunction

  task automatic set_in(input int rs, input int rt, input bit uses_rt, input bit is_br,
                        input bit taken, input bit hilo, input bit md,
                        input int exwr, input bit exrw, input bit exmr, input bit start,
                        input int memwr, input bit memmr);
    bus.ID_rs          = 5'(rs);
    bus.ID_rt          = 5'(rt);
    bus.ID_usesRt      = uses_rt;
    bus.ID_isBranch    = is_br;
    bus.ID_BranchTaken = taken;
    bus.ID_readsHiLo   = hilo;
    bus.ID_isMulDiv    = md;
    bus.EX_WriteReg    = 5'(exwr);
    bus.EX_RegWrite    = exrw;
    bus.EX_MemRead     = exmr;
    bus.EX_MulDivStart = start;
    bus.MEM_WriteReg   = 5'(memwr);
    bus.MEM_MemRead    = memmr;
  endtask

  task automatic idle_in();
    set_in(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
  endtask

  // Check one cycle mid-period, then advance the model across the rising edge.
  task automatic step();
    bit s;
    #1;
    if (Reset) begin
      m_rem = 0; m_done = 1'b0; m_ovl = 1'b0; m_cnt = 0;
    end
    s = model_stall();
    chk("PCWrite",     32'(bus.PCWrite),     Reset ? 32'd1 : 32'(!s));
    chk("IFID_Write",  32'(bus.IFID_Write),  Reset ? 32'd1 : 32'(!s));
    chk("IDEX_Bubble", 32'(bus.IDEX_Bubble), Reset ? 32'd0 : 32'(s));
    chk("IFID_Flush",  32'(bus.IFID_Flush),  Reset ? 32'd0 : 32'(bus.ID_BranchTaken && !s));
    chk("MD_Busy",     32'(bus.MD_Busy),     32'(m_rem > 0));
    chk("MD_Done",     32'(bus.MD_Done),     32'(m_done));
    chk("MD_Overlap",  32'(bus.MD_Overlap),  32'(m_ovl));
    chk("StallCount",  32'(bus.StallCount),  32'(m_cnt));
    @(posedge Clk);
    if (Reset) begin
      m_rem = 0; m_done = 1'b0; m_ovl = 1'b0; m_cnt = 0;
    end else begin
      m_done = (m_rem == 1);
      if (m_rem > 0) begin
        if (bus.EX_MulDivStart) m_ovl = 1'b1;
        m_rem--;
      end else if (bus.EX_MulDivStart) begin
        m_rem = LAT;
      end
      if (s && (m_cnt < CMAX)) m_cnt++;
    end
    #2;
  endtask

  initial begin
    idle_in();
    #2;
    step();
    step();
    Reset = 1'b0;
    step();

    // load-use on rs, then rt without usesRt
    set_in(8, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8, 1'b1, 1'b1, 1'b0, 0, 1'b0);
    step();
    set_in(1, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8, 1'b1, 1'b1, 1'b0, 0, 1'b0);
    step();
    // branch vs ALU producer in EX, then same producer in MEM (non-load)
    set_in(9, 3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 9, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    step();
    set_in(9, 3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 9, 1'b0);
    step();
    // $0 never stalls; branch vs load in MEM on rt
    set_in(0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b1, 1'b0, 0, 1'b0);
    step();
    set_in(2, 5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 5, 1'b1);
    step();

    // MUL/DIV start with mflo waiting, then back-to-back start on the done cycle
    set_in(0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b1, 0, 1'b0);
    step();
    bus.EX_MulDivStart = 1'b0;
    repeat (4) step();
    bus.EX_MulDivStart = 1'b1;
    step();
    bus.EX_MulDivStart = 1'b0;
    step();
    // overlap while busy, then async reset mid-busy
    bus.EX_MulDivStart = 1'b1;
    step();
    bus.EX_MulDivStart = 1'b0;
    step();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    repeat (2) step();

    // saturation of the narrow counter
    set_in(7, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7, 1'b1, 1'b1, 1'b0, 0, 1'b0);
    repeat (20) step();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    idle_in();
    step();

    // randomized traffic over a small register window
    for (int i = 0; i < 600; i++) begin
      set_in($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), 1'($urandom),
             1'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0),
             $urandom_range(0, 3), 1'($urandom), ($urandom_range(0, 2) == 0),
             ($urandom_range(0, 5) == 0), $urandom_range(0, 3), ($urandom_range(0, 2) == 0));
      Reset = ($urandom_range(0, 59) == 0);
      step();
    end
    Reset = 1'b0;
    idle_in();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
